// File: rtl/truth_table_sequencer.sv
// Clocked truth-table sweep: drives every input vector in ascending order, holds it
// for DWELL+1 cycles, compares the sampled outputs against a golden table and keeps results.
`timescale 1ns/1ps
module truth_table_sequencer #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter int DWELL = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [(2**N_IN)*N_OUT-1:0]  golden,
    output logic [N_IN-1:0]             dut_in,
    input  logic [N_OUT-1:0]            dut_out,
    output logic                        busy,
    output logic                        done,
    output logic [N_IN:0]               err_count,
    output logic [2**N_IN-1:0]          err_mask,
    input  logic [N_IN-1:0]             rd_addr,
    output logic [N_OUT-1:0]            rd_data
);

    localparam int N_VEC = 2**N_IN;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_IN-1:0]       r_vec;
    logic [CNT_W-1:0]      r_cnt;
    logic [N_IN-1:0]       r_dut_in;
    logic [N_IN:0]         r_err_count;
    logic [N_VEC-1:0]      r_err_mask;
    logic [N_OUT-1:0]      r_result [N_VEC];

    logic                  w_load;
    logic                  w_dec;
    logic                  w_capture;
    logic                  w_advance;
    logic                  w_abort;
    logic                  w_last;
    logic [N_OUT-1:0]      w_golden;
    logic                  w_mismatch;

    assign w_last     = &r_vec;
    assign w_golden   = golden[int'(r_vec)*N_OUT +: N_OUT];
    assign w_mismatch = (dut_out != w_golden);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // abort outranks the SAMPLE capture; start is only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_APPLY;
                    w_load      = 1'b1;
                end
            end
            S_APPLY: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_capture = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_APPLY;
                        w_advance   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec       <= '0;
            r_cnt       <= '0;
            r_dut_in    <= '0;
            r_err_count <= '0;
            r_err_mask  <= '0;
        end else begin
            if (w_load) begin
                r_vec       <= '0;
                r_cnt       <= CNT_RELOAD;
                r_dut_in    <= '0;
                r_err_count <= '0;
                r_err_mask  <= '0;
            end else if (w_abort) begin
                r_vec    <= '0;
                r_cnt    <= '0;
                r_dut_in <= '0;
            end else begin
                if (w_dec) begin
                    r_cnt <= r_cnt - 1'b1;
                end
                if (w_capture && w_mismatch) begin
                    r_err_mask[r_vec] <= 1'b1;
                    r_err_count       <= r_err_count + 1'b1;
                end
                if (w_advance) begin
                    r_vec    <= r_vec + 1'b1;
                    r_dut_in <= r_vec + 1'b1;
                    r_cnt    <= CNT_RELOAD;
                end
            end
        end
    end

    // Result store is overwritten per sweep, never bulk-cleared except by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_VEC; i++) begin
                r_result[i] <= '0;
            end
        end else if (w_capture) begin
            r_result[r_vec] <= dut_out;
        end
    end

    assign dut_in    = r_dut_in;
    assign busy      = (r_state == S_APPLY) || (r_state == S_SAMPLE);
    assign done      = (r_state == S_DONE);
    assign err_count = r_err_count;
    assign err_mask  = r_err_mask;
    assign rd_data   = r_result[rd_addr];

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: a DWELL=1 instance and a default instance
// driving a small behavioural logic unit (d = a&b, e = b|c).
`timescale 1ns/1ps
module tb_truth_table_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        start_a = 1'b0, abort_a = 1'b0;
    logic [15:0] golden_a = '0;
    logic [2:0]  dut_in_a;
    logic [1:0]  dut_out_a;
    logic        busy_a, done_a;
    logic [3:0]  err_count_a;
    logic [7:0]  err_mask_a;
    logic [2:0]  rd_addr_a = '0;
    logic [1:0]  rd_data_a;
    logic        mode_model = 1'b1;
    logic [1:0]  const_a = 2'b00;

    logic        start_b = 1'b0, abort_b = 1'b0;
    logic [15:0] golden_b = '0;
    logic [2:0]  dut_in_b;
    logic [1:0]  dut_out_b = 2'b00;
    logic        busy_b, done_b;
    logic [3:0]  err_count_b;
    logic [7:0]  err_mask_b;
    logic [2:0]  rd_addr_b = '0;
    logic [1:0]  rd_data_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (mode_model)
            dut_out_a = {dut_in_a[2] & dut_in_a[1], dut_in_a[1] | dut_in_a[0]};
        else
            dut_out_a = const_a;
    end

    truth_table_sequencer #(.N_IN(3), .N_OUT(2), .DWELL(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .golden(golden_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .err_count(err_count_a), .err_mask(err_mask_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a)
    );

    truth_table_sequencer #(.N_IN(3), .N_OUT(2), .DWELL(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .golden(golden_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .err_count(err_count_b), .err_mask(err_mask_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns the number of the edge (start-accept edge = 0) that captures done high.
    // Position k is the negedge just before edge k. Leaves the block back in IDLE.
    task automatic sweep_a(input int extra_start_k, output int edge_n);
        edge_n = -1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            start_a = (k == extra_start_k);
            if (done_a === 1'b1) begin
                edge_n = k;
                break;
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  edge_n;
        logic saw_done;

        #2 rst_n = 1'b0;
        #2;
        chk("rst_dut_in", dut_in_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err_count", err_count_a, 0);
        chk("rst_err_mask", err_mask_a, 0);
        chk("rst_rd_data", rd_data_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // DWELL=1: each vector held two cycles, done captured by edge 17
        edge_n = -1;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k <= 16) chk("b_dut_in", dut_in_b, (k - 1) / 2);
            if (done_b === 1'b1) begin
                edge_n = k;
                break;
            end
            @(negedge clk);
        end
        chk("b_done_edge", edge_n, 17);
        @(negedge clk);
        chk("b_err_count", err_count_b, 0);
        chk("b_err_mask", err_mask_b, 8'h00);
        for (int v = 0; v < 8; v++) begin
            rd_addr_b = 3'(v);
            #1 chk("b_rd_data", rd_data_b, 0);
        end

        // Golden table hand-computed for d=a&b, e=b|c: vectors 7..0 = 11 11 01 00 01 01 01 00
        mode_model = 1'b1;
        golden_a   = 16'hF454;
        sweep_a(0, edge_n);
        chk("clean_done_edge", edge_n, 41);
        chk("clean_err_count", err_count_a, 0);
        chk("clean_err_mask", err_mask_a, 8'h00);
        rd_addr_a = 3'b111; #1 chk("rd_111", rd_data_a, 2'b11);
        rd_addr_a = 3'b100; #1 chk("rd_100", rd_data_a, 2'b00);
        rd_addr_a = 3'b101; #1 chk("rd_101", rd_data_a, 2'b01);

        // Vector 5, output d flipped in the golden table
        golden_a = 16'hFC54;
        sweep_a(0, edge_n);
        chk("flip_done_edge", edge_n, 41);
        chk("flip_err_count", err_count_a, 1);
        chk("flip_err_mask", err_mask_a, 8'h20);

        // Unit stuck at 01 against an all-zero table
        mode_model = 1'b0;
        const_a    = 2'b01;
        golden_a   = 16'h0000;
        sweep_a(0, edge_n);
        chk("stuck_err_count", err_count_a, 4'b1000);
        chk("stuck_err_mask", err_mask_a, 8'hFF);
        rd_addr_a = 3'b011; #1 chk("stuck_rd_011", rd_data_a, 2'b01);

        // Abort during APPLY of vector 3 (cycle starting at edge 15)
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_pre_dut_in", dut_in_a, 3);
        chk("abort_pre_busy", busy_a, 1);
        abort_a = 1'b1;
        @(negedge clk); abort_a = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_dut_in", dut_in_a, 0);
        chk("abort_err_count", err_count_a, 3);
        chk("abort_err_mask", err_mask_a, 8'h07);
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done_a === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", saw_done, 0);

        // Clean sweep after abort, with a stray start pulse while busy
        mode_model = 1'b1;
        golden_a   = 16'hF454;
        sweep_a(10, edge_n);
        chk("restart_done_edge", edge_n, 41);
        chk("restart_err_count", err_count_a, 0);
        chk("restart_err_mask", err_mask_a, 8'h00);

        // Asynchronous reset while vector 4 is applied
        mode_model = 1'b0;
        const_a    = 2'b01;
        golden_a   = 16'h0000;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (21) @(negedge clk);
        chk("mid_dut_in", dut_in_a, 4);
        chk("mid_err_count", err_count_a, 4);
        rd_addr_a = 3'b000;
        #1 chk("mid_rd_000", rd_data_a, 2'b01);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_dut_in", dut_in_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_done", done_a, 0);
        chk("arst_err_count", err_count_a, 0);
        chk("arst_err_mask", err_mask_a, 0);
        chk("arst_rd_000", rd_data_a, 0);
        @(negedge clk); rst_n = 1'b1;
        mode_model = 1'b1;
        golden_a   = 16'hF454;
        sweep_a(0, edge_n);
        chk("post_rst_done_edge", edge_n, 41);
        chk("post_rst_err_count", err_count_a, 0);
        rd_addr_a = 3'b111; #1 chk("post_rst_rd_111", rd_data_a, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
